// File: rtl/ineq_sweep_checker.sv
// On-chip self-test for the 4-in/3-out inequality unit: sweeps every input code, compares each response against a golden table.
// Optional INEQ_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module ineq_sweep_checker #(
  parameter int NUM_W  = 4,
  parameter int OUT_W  = 3,
  parameter int SETTLE = 2,
  parameter logic [OUT_W*(2**NUM_W)-1:0] EXPECT = 48'h922249249249
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OUT_W-1:0] dut_out,
  output logic [NUM_W-1:0] num_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NUM_W:0]   fail_count,
  output logic [NUM_W-1:0] first_fail_num,
  output logic [OUT_W-1:0] first_fail_got
);

  localparam int NUM_VEC = 2**NUM_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0]       SETTLE_RELOAD = 4'(SETTLE - 1);
  localparam logic [NUM_W-1:0] NUM_MAX       = '1;
  localparam logic [NUM_W-1:0] NUM_ONE       = NUM_W'(1);
  localparam logic [NUM_W:0]   FAIL_MAX      = (NUM_W + 1)'(NUM_VEC);
  localparam logic [NUM_W:0]   FAIL_ONE      = (NUM_W + 1)'(1);

  logic [1:0]       state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NUM_W:0]   fail_q, fail_d;
  logic [NUM_W-1:0] ff_num_q, ff_num_d;
  logic [OUT_W-1:0] ff_got_q, ff_got_d;

  logic [OUT_W-1:0] golden [NUM_VEC];
  logic             mismatch;

  for (genvar g = 0; g < NUM_VEC; g++) begin : g_table
    assign golden[g] = EXPECT[OUT_W*g +: OUT_W];
  end

  assign mismatch = (dut_out != golden[num_q]);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    ff_num_d = ff_num_q;
    ff_got_d = ff_got_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d    = '0;
          fail_d   = '0;
          ff_num_d = '0;
          ff_got_d = '0;
          cnt_d    = SETTLE_RELOAD;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (fail_q != FAIL_MAX) fail_d = fail_q + FAIL_ONE;
          if (fail_q == '0) begin
            ff_num_d = num_q;
            ff_got_d = dut_out;
          end
        end
`ifdef INEQ_SWEEP_STOP_ON_FAIL_EN
        if (mismatch || num_q == NUM_MAX) begin
`else
        if (num_q == NUM_MAX) begin
`endif
          state_d = S_DONE;
        end else begin
          num_d   = num_q + NUM_ONE;
          cnt_d   = SETTLE_RELOAD;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      ff_num_q <= '0;
      ff_got_q <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      ff_num_q <= ff_num_d;
      ff_got_q <= ff_got_d;
    end
  end

  // Status decodes straight from state, so reset clears them without a clock edge.
  assign num_out        = num_q;
  assign busy           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (fail_q == '0);
  assign fail_count     = fail_q;
  assign first_fail_num = ff_num_q;
  assign first_fail_got = ff_got_q;

endmodule

// File: tb/tb_ineq_sweep_checker.sv
// Bench for ineq_sweep_checker: behavioural inequality unit with injectable faults and a sweep-level reference model.
module tb_ineq_sweep_checker;

  localparam int VEC_CYC = 3;
  localparam int NVEC    = 16;
`ifdef INEQ_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] dut_out;
  logic [3:0] num_out;
  logic       busy, done, pass;
  logic [4:0] fail_count;
  logic [3:0] first_fail_num;
  logic [2:0] first_fail_got;

  logic       fault_en  [NVEC];
  logic [2:0] fault_val [NVEC];
  logic [2:0] golden_tab[NVEC];

  int total = 0;
  int bad   = 0;
  int exp_cnt, exp_ffn, exp_ffg, exp_lat, exp_last;

  always #5 clk = ~clk;

  ineq_sweep_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dut_out        (dut_out),
    .num_out        (num_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_num (first_fail_num),
    .first_fail_got (first_fail_got)
  );

  assign dut_out = fault_en[num_out] ? fault_val[num_out] : golden_tab[num_out];

  function automatic logic [2:0] golden(input int n);
    return {n > 12, n == 12, n < 12};
  endfunction

  function automatic logic [2:0] unit_model(input int n);
    return fault_en[n] ? fault_val[n] : golden(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int n = 0; n < NVEC; n++) begin
      fault_en[n]  = 1'b0;
      fault_val[n] = 3'b000;
    end
  endtask

  task automatic ref_model();
    exp_cnt  = 0;
    exp_ffn  = 0;
    exp_ffg  = 0;
    exp_lat  = NVEC * VEC_CYC;
    exp_last = NVEC - 1;
    for (int n = 0; n < NVEC; n++) begin
      logic [2:0] got;
      got = unit_model(n);
      if (got != golden(n)) begin
        if (exp_cnt == 0) begin
          exp_ffn = n;
          exp_ffg = int'(got);
        end
        exp_cnt++;
        if (STOP_MODE) begin
          exp_lat  = (n + 1) * VEC_CYC;
          exp_last = n;
          break;
        end
      end
    end
  endtask

  // Start a sweep (optionally pulsing start again mid-sweep) and check the final report.
  task automatic run_sweep(input string tag, input int restart_at);
    int k;
    bit seq_ok;
    ref_model();
    seq_ok = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_pass_drop"}, 32'(pass), 32'd0);
    while (done !== 1'b1 && k < 200) begin
      if (busy !== 1'b1 || num_out !== 4'(k / VEC_CYC)) seq_ok = 1'b0;
      start = (k == restart_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_latency"},  32'(k),              32'(exp_lat));
    check({tag, "_sequence"}, 32'(seq_ok),         32'd1);
    check({tag, "_done"},     32'(done),           32'd1);
    check({tag, "_busy"},     32'(busy),           32'd0);
    check({tag, "_pass"},     32'(pass),           32'(exp_cnt == 0));
    check({tag, "_fcount"},   32'(fail_count),     32'(exp_cnt));
    check({tag, "_ffnum"},    32'(first_fail_num), 32'(exp_ffn));
    check({tag, "_ffgot"},    32'(first_fail_got), 32'(exp_ffg));
    check({tag, "_last_num"}, 32'(num_out),        32'(exp_last));
    @(negedge clk);
    check({tag, "_done_hold"}, 32'(done), 32'd1);
  endtask

  initial begin
    int w;
    for (int n = 0; n < NVEC; n++) golden_tab[n] = golden(n);
    clear_faults();
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    check("rst_num",  32'(num_out),    32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_done", 32'(done),       32'd0);
    check("rst_pass", 32'(pass),       32'd0);
    check("rst_fcnt", 32'(fail_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    run_sweep("clean", -1);

    clear_faults();
    fault_en[12] = 1'b1;
    run_sweep("fault12", -1);

    for (int n = 0; n < NVEC; n++) begin
      fault_en[n]  = 1'b1;
      fault_val[n] = ~golden(n);
    end
    run_sweep("invert", -1);

    clear_faults();
    run_sweep("restart_busy", 20);
    run_sweep("restart_done", -1);

    clear_faults();
    fault_en[5]  = 1'b1;
    fault_val[5] = 3'b100;
    run_sweep("fault5", -1);

    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < NVEC; n++) begin
        fault_en[n]  = ($urandom_range(0, 3) == 0);
        fault_val[n] = 3'($urandom_range(0, 7));
      end
      run_sweep($sformatf("rand%0d", r), -1);
    end

    // Asynchronous reset in the middle of a vector hold.
    clear_faults();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (num_out !== 4'd7 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_reach7", 32'(num_out), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_num",  32'(num_out),        32'd0);
    check("arst_busy", 32'(busy),           32'd0);
    check("arst_done", 32'(done),           32'd0);
    check("arst_pass", 32'(pass),           32'd0);
    check("arst_fcnt", 32'(fail_count),     32'd0);
    check("arst_ffn",  32'(first_fail_num), 32'd0);
    check("arst_ffg",  32'(first_fail_got), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(busy),    32'd0);
    check("post_rst_num",  32'(num_out), 32'd0);
    check("post_rst_done", 32'(done),    32'd0);

    run_sweep("after_rst", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ineq_sweep_checker.md
Name: ineq_sweep_checker

Overview:
- Synthesizable stimulus/response engine for the 4-bit-in / 3-bit-out inequality unit.
- Walks NUM through every input code, waits a settle time, samples the unit's OUT, and compares it against a golden table.
- Reports pass/fail, a mismatch count and the first failing vector.
- Sits beside the inequality unit as on-chip self-test. It drives the unit's input and reads its output.

Parameters:
- NUM_W, 4, width of the stimulus driven to the unit.
- OUT_W, 3, width of the unit's response.
- SETTLE, 2, cycles num_out is held before sampling; legal range 1..15.
- EXPECT, 48'h922249249249, golden table. Entry n is EXPECT[OUT_W*n +: OUT_W].
  - Default encodes {n>12, n==12, n<12}, so n=12 gives 3'b010.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep
- dut_out  in  OUT_W  response from the inequality unit
- num_out  out  NUM_W  stimulus to the inequality unit
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until the next accepted start
- pass  out  1  done && fail_count==0
- fail_count  out  NUM_W+1  number of mismatching vectors, 0..16
- first_fail_num  out  NUM_W  stimulus of the first mismatch
- first_fail_got  out  OUT_W  dut_out captured at the first mismatch

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset (rst_n=0, immediate, any state):
  - state=IDLE.
  - num_out=0, busy=0, done=0, pass=0, fail_count=0.
  - first_fail_num=0, first_fail_got=0.
  - Settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1: num_out=0, fail_count=0, first_fail_* cleared, settle counter=SETTLE-1, busy=1, go to DRIVE.
- DRIVE:
  - num_out held.
  - Counter decrements each cycle. At counter==0, go to SAMPLE next cycle.
  - Total time in DRIVE is SETTLE cycles.
- SAMPLE (one cycle):
  - Compare dut_out with the EXPECT entry for num_out.
  - On mismatch: fail_count++. If fail_count was 0, capture first_fail_num=num_out and first_fail_got=dut_out.
  - If num_out == 2^NUM_W-1: go to DONE.
  - Otherwise: num_out++, counter reloads to SETTLE-1, go to DRIVE.
- DONE:
  - busy=0, done=1, pass=(fail_count==0).
  - num_out holds the last vector.
  - start=1 restarts exactly as from IDLE and drops done/pass in the same cycle.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - done rises 2^NUM_W*(SETTLE+1) cycles after the start edge. Default: 48 cycles.
- start while busy is ignored; no restart, no counter change.
- fail_count saturates at 2^NUM_W, which is reachable only when every vector fails. No wrap.
- num_out never wraps within a sweep. The increment happens only when not at the maximum.
- dut_out is sampled only in SAMPLE. Glitches during DRIVE are ignored.
- pass is 0 whenever done=0.

Optional Feature:
- Macro: INEQ_SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch in SAMPLE records the failure (fail_count=1, first_fail_* captured) and goes directly to DONE.
  - num_out freezes at the failing vector; pass=0.
- Undefined:
  - The full sweep always runs. fail_count counts every mismatch.

Test Plan:
- Correct model, default params: pulse start.
  - Expect busy=1 for 48 cycles, num_out 0..15 in order, each held 3 cycles.
  - Then done=1, pass=1, fail_count=0.
- Model forced to return 3'b000 at NUM=12 only.
  - Expect done after 48 cycles, pass=0, fail_count=1, first_fail_num=12, first_fail_got=3'b000.
- Model inverted on every vector.
  - Expect fail_count=16, first_fail_num=0, first_fail_got=3'b110, pass=0.
- start pulsed again at cycle 20 of a sweep.
  - Expect no effect; done still at cycle 48.
  - A second start in DONE clears done/pass/fail_count and re-sweeps from num_out=0.
- rst_n driven low during DRIVE with num_out=7.
  - Expect all outputs at reset values immediately, without waiting for a clock edge.
  - After release, IDLE until start.
- With INEQ_SWEEP_STOP_ON_FAIL_EN and a fault at NUM=5.
  - Expect done at cycle 18 (6 vectors × 3), num_out=5, fail_count=1, pass=0.
